// File: rtl/serial_cla_adder_pkg.sv
// Shared definitions for the serial carry-lookahead adder.
// Slice width, FSM state encodings and the default operand width.
package serial_cla_adder_pkg;

    localparam int SLICE_W   = 4;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cla_adder_slice.sv
// Combinational 4-bit carry-lookahead slice.
// c_o[3] is the slice carry-out; c_o[i] is the carry out of bit i.
module cla_slice4
    import serial_cla_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c0_i,
    output logic [SLICE_W-1:0] s_o,
    output logic [SLICE_W-1:0] c_o,
    output logic [SLICE_W-1:0] p_o,
    output logic [SLICE_W-1:0] g_o
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Flattened lookahead carries: every carry depends only on p, g and c0.
    always_comb begin
        c_o[0] = g[0] | (p[0] & c0_i);
        c_o[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
        c_o[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c0_i);
        c_o[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0_i);
    end

    assign s_o = p ^ {c_o[2:0], c0_i};
    assign p_o = p;
    assign g_o = g;

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit CLA slice.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the 'sub' port.
module serial_cla_adder
    import serial_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int IW = $clog2(N);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("serial_cla_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_s, sl_c, sl_p, sl_g;
    logic               unused_sl;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1, folded in when the operands are latched.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

    cla_slice4 u_slice (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .c0_i (carry_q),
        .s_o  (sl_s),
        .c_o  (sl_c),
        .p_o  (sl_p),
        .g_o  (sl_g)
    );

    assign unused_sl = ^{sl_c[1:0], sl_p, sl_g};

    // Next-state: accept in IDLE/DONE, process one slice per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    sum_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
                carry_d = sl_c[3];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    cout_d  = sl_c[3];
                    ovf_d   = sl_c[2] ^ sl_c[3];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed-vector bench for serial_cla_adder (WIDTH=32, 8 slices).
// Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_cla_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int vecs = 0;
    int errs = 0;

    serial_cla_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv);
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(inout int n);
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL reset_flags: busy/done=%b want 00", {busy, done}); end
        vecs++; if ({sum, cout, overflow} !== {W'(0), 2'b00}) begin errs++; $display("FAIL reset_result: sum=%h cout=%b ovf=%b want 0", sum, cout, overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n = 0;
        launch(32'd7, 32'd7, 1'b1);
        vecs++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL basic_busy: busy/done=%b want 10", {busy, done}); end
        wait_done(n);
        vecs++; if (n !== 8) begin errs++; $display("FAIL basic_latency: edges=%0d want 8", n); end
        vecs++; if (sum !== 32'h0000000F) begin errs++; $display("FAIL basic_sum: got %h want 0000000f", sum); end
        vecs++; if ({cout, overflow, busy} !== 3'b000) begin errs++; $display("FAIL basic_flags: cout/ovf/busy=%b want 000", {cout, overflow, busy}); end
        tick();
        vecs++; if ({done, sum} !== {1'b0, 32'h0000000F}) begin errs++; $display("FAIL basic_hold: done=%b sum=%h want 0/0000000f", done, sum); end
    endtask

    task automatic test_wrap();
        int n = 0;
        launch(32'hFFFFFFFF, 32'h1, 1'b0);
        wait_done(n);
        vecs++; if (sum !== 32'h0) begin errs++; $display("FAIL wrap_sum: got %h want 00000000", sum); end
        vecs++; if ({cout, overflow} !== 2'b10) begin errs++; $display("FAIL wrap_flags: cout/ovf=%b want 10", {cout, overflow}); end
        tick();
    endtask

    task automatic test_overflow();
        int n = 0;
        launch(32'h7FFFFFFF, 32'h1, 1'b0);
        wait_done(n);
        vecs++; if (sum !== 32'h80000000) begin errs++; $display("FAIL ovf_sum: got %h want 80000000", sum); end
        vecs++; if ({cout, overflow} !== 2'b01) begin errs++; $display("FAIL ovf_flags: cout/ovf=%b want 01", {cout, overflow}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        launch(32'h12345678, 32'h11111111, 1'b0);
        tick();
        tick();
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 3;
        wait_done(n);
        vecs++; if (n !== 8) begin errs++; $display("FAIL ignore_latency: edges=%0d want 8", n); end
        vecs++; if (sum !== 32'h23456789) begin errs++; $display("FAIL ignore_sum: got %h want 23456789", sum); end
        n = 0;
        launch(32'd9, 32'd9, 1'b0);
        vecs++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL b2b_nobubble: busy/done=%b want 10", {busy, done}); end
        wait_done(n);
        vecs++; if (n !== 8) begin errs++; $display("FAIL b2b_latency: edges=%0d want 8", n); end
        vecs++; if ({sum, cout} !== {32'd18, 1'b0}) begin errs++; $display("FAIL b2b_sum: sum=%h cout=%b want 00000012/0", sum, cout); end
        tick();
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        launch(32'd1, 32'd2, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL abort_flags: busy/done=%b want 00", {busy, done}); end
        vecs++; if (sum !== 32'h0) begin errs++; $display("FAIL abort_sum: got %h want 00000000", sum); end
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            tick();
        end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL abort_nodone: done cycles=%0d want 0", seen); end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int n = 0;
        sub = 1'b1;
        launch(32'd5, 32'd9, 1'b0);
        sub = 1'b0;
        wait_done(n);
        vecs++; if ({sum, cout} !== {32'hFFFFFFFC, 1'b0}) begin errs++; $display("FAIL sub_neg: sum=%h cout=%b want fffffffc/0", sum, cout); end
        tick();
        n = 0;
        sub = 1'b1;
        launch(32'd9, 32'd5, 1'b0);
        sub = 1'b0;
        wait_done(n);
        vecs++; if ({sum, cout} !== {32'd4, 1'b1}) begin errs++; $display("FAIL sub_pos: sum=%h cout=%b want 00000004/1", sum, cout); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
